xbar_credit_arbiter: RTL and testbench

- Front-end scheduler for the PE-to-accumulator crossbar.
- Arbitrates NUM_SRC PE output streams onto NUM_DST accumulate-buffer banks. Destination = packet index mod NUM_DST.
- Round-robin per destination, at most one packet per destination per cycle.
- Credit-based flow control, so a bank never receives more packets than it has buffer slots. This replaces unbounded multi-push into a single bank FIFO.

---
 rtl/xbar_credit_arbiter.sv | 167 ++++++++++++++++
 tb/tb_xbar_credit_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/xbar_credit_arbiter.sv
// xbar_credit_arbiter
// Front-end scheduler for the PE-to-accumulator crossbar. Each PE source
// presents one packet; its bank is the low log2(NUM_DST) bits of the packet
// index. Every bank runs its own round-robin pointer and credit counter, so a
// bank never holds more packets than it has buffer slots, and different banks
// grant independently in the same cycle.
//
// Optional feature: define XBAR_ARB_STATS_EN to add the stall_count output,
// one saturating 16-bit counter per bank that counts cycles in which the bank
// has at least one requester but no credit.
//
// Handshake: a source raises src_valid with stable index/data and holds them
// until it sees src_ready in the same cycle; the transfer happens on the
// clock edge where src_valid & src_ready are both high. src_ready is a pure
// function of src_valid/src_index and registered arbiter state. The bank side
// is a push-only strobe (dst_valid for one cycle) paced by dst_credit_return.
module xbar_credit_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int NUM_DST = 4,
  parameter int DATA_W  = 32,
  parameter int IDX_W   = 8,
  parameter int CREDITS = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [NUM_SRC*IDX_W-1:0]  src_index,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  output logic [NUM_SRC-1:0]        src_ready,
  output logic [NUM_DST-1:0]        dst_valid,
  output logic [NUM_DST*IDX_W-1:0]  dst_index,
  output logic [NUM_DST*DATA_W-1:0] dst_data,
  input  logic [NUM_DST-1:0]        dst_credit_return,
  output logic                      busy
`ifdef XBAR_ARB_STATS_EN
  ,
  output logic [NUM_DST*16-1:0]     stall_count
`endif
);

  localparam int DST_W = (NUM_DST > 1) ? $clog2(NUM_DST) : 1;
  localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int CRD_W = $clog2(CREDITS + 1);
  localparam logic [CRD_W-1:0] CRD_MAX = CRD_W'(CREDITS);

  logic [DST_W-1:0]          src_dst   [NUM_SRC];
  logic [NUM_SRC-1:0]        req       [NUM_DST];
  logic [NUM_DST-1:0]        gnt_vld;
  logic [SRC_W-1:0]          gnt_src   [NUM_DST];

  logic [CRD_W-1:0]          credit_q  [NUM_DST];
  logic [CRD_W-1:0]          credit_d  [NUM_DST];
  logic [SRC_W-1:0]          rr_ptr_q  [NUM_DST];
  logic [SRC_W-1:0]          rr_ptr_d  [NUM_DST];

  logic [NUM_DST-1:0]        dst_valid_q;
  logic [NUM_DST*IDX_W-1:0]  dst_index_q;
  logic [NUM_DST*DATA_W-1:0] dst_data_q;

  // Decode each source's bank and build the per-bank requester masks.
  always_comb begin
    for (int s = 0; s < NUM_SRC; s++) begin
      if (NUM_DST == 1) src_dst[s] = '0;
      else              src_dst[s] = src_index[s*IDX_W +: DST_W];
    end
    for (int d = 0; d < NUM_DST; d++) begin
      req[d] = '0;
      for (int s = 0; s < NUM_SRC; s++) begin
        req[d][s] = src_valid[s] && (src_dst[s] == DST_W'(d));
      end
    end
  end

  // Per bank: with credit available, grant the first requester found scanning
  // cyclically from the round-robin pointer. Nothing is granted during reset.
  always_comb begin
    for (int d = 0; d < NUM_DST; d++) begin
      gnt_vld[d] = 1'b0;
      gnt_src[d] = '0;
      if (!reset && credit_q[d] != '0) begin
        for (int k = 0; k < NUM_SRC; k++) begin
          if (!gnt_vld[d] && req[d][(int'(rr_ptr_q[d]) + k) % NUM_SRC]) begin
            gnt_vld[d] = 1'b1;
            gnt_src[d] = SRC_W'((int'(rr_ptr_q[d]) + k) % NUM_SRC);
          end
        end
      end
    end
  end

  // Fold the per-bank grants back onto the sources and flag stalled sources.
  always_comb begin
    src_ready = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      for (int d = 0; d < NUM_DST; d++) begin
        if (gnt_vld[d] && gnt_src[d] == SRC_W'(s)) src_ready[s] = 1'b1;
      end
    end
    busy = !reset && (|(src_valid & ~src_ready));
  end

  // Next pointer and credit: a grant consumes a slot, a return frees one
  // (saturating at CREDITS), both together cancel out.
  always_comb begin
    for (int d = 0; d < NUM_DST; d++) begin
      rr_ptr_d[d] = rr_ptr_q[d];
      credit_d[d] = credit_q[d];
      if (gnt_vld[d]) rr_ptr_d[d] = SRC_W'((int'(gnt_src[d]) + 1) % NUM_SRC);
      case ({gnt_vld[d], dst_credit_return[d]})
        2'b10:   credit_d[d] = credit_q[d] - 1'b1;
        2'b01:   if (credit_q[d] < CRD_MAX) credit_d[d] = credit_q[d] + 1'b1;
        default: credit_d[d] = credit_q[d];
      endcase
    end
  end

  // Arbiter state and the registered bank-side packet strobe.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int d = 0; d < NUM_DST; d++) begin
        credit_q[d] <= CRD_MAX;
        rr_ptr_q[d] <= '0;
      end
      dst_valid_q <= '0;
      dst_index_q <= '0;
      dst_data_q  <= '0;
    end else begin
      for (int d = 0; d < NUM_DST; d++) begin
        credit_q[d] <= credit_d[d];
        rr_ptr_q[d] <= rr_ptr_d[d];
        dst_valid_q[d] <= gnt_vld[d];
        if (gnt_vld[d]) begin
          dst_index_q[d*IDX_W +: IDX_W]   <= src_index[int'(gnt_src[d])*IDX_W +: IDX_W];
          dst_data_q[d*DATA_W +: DATA_W]  <= src_data[int'(gnt_src[d])*DATA_W +: DATA_W];
        end
      end
    end
  end

  assign dst_valid = dst_valid_q;
  assign dst_index = dst_index_q;
  assign dst_data  = dst_data_q;

`ifdef XBAR_ARB_STATS_EN
  logic [15:0] stall_q [NUM_DST];

  // Count cycles where a bank is wanted but has no credit; saturate at max.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int d = 0; d < NUM_DST; d++) stall_q[d] <= '0;
    end else begin
      for (int d = 0; d < NUM_DST; d++) begin
        if ((|req[d]) && credit_q[d] == '0 && stall_q[d] != 16'hFFFF) begin
          stall_q[d] <= stall_q[d] + 16'd1;
        end
      end
    end
  end

  // Pack the per-bank counters onto the flat output.
  always_comb begin
    stall_count = '0;
    for (int d = 0; d < NUM_DST; d++) stall_count[d*16 +: 16] = stall_q[d];
  end
`endif

endmodule

// File: tb/tb_xbar_credit_arbiter.sv
// Directed bench for xbar_credit_arbiter (default parameters 4x4, 32-bit data,
// 8-bit index, 4 credits). Inputs change 1 time unit after the rising edge;
// outputs are sampled 1 time unit later, well away from the next edge.
module tb_xbar_credit_arbiter;

  logic         clock = 1'b0;
  logic         reset;
  logic [3:0]   src_valid;
  logic [31:0]  src_index;
  logic [127:0] src_data;
  logic [3:0]   src_ready;
  logic [3:0]   dst_valid;
  logic [31:0]  dst_index;
  logic [127:0] dst_data;
  logic [3:0]   dst_credit_return;
  logic         busy;
`ifdef XBAR_ARB_STATS_EN
  logic [63:0]  stall_count;
`endif

  int checks   = 0;
  int failures = 0;

  xbar_credit_arbiter dut (
    .clock             (clock),
    .reset             (reset),
    .src_valid         (src_valid),
    .src_index         (src_index),
    .src_data          (src_data),
    .src_ready         (src_ready),
    .dst_valid         (dst_valid),
    .dst_index         (dst_index),
    .dst_data          (dst_data),
    .dst_credit_return (dst_credit_return),
    .busy              (busy)
`ifdef XBAR_ARB_STATS_EN
    ,
    .stall_count       (stall_count)
`endif
  );

  // Clock and watchdog.
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  // Driver tasks.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_src(input int s, input logic v, input logic [7:0] idx,
                         input logic [31:0] dat);
    src_valid[s]          = v;
    src_index[s*8 +: 8]   = idx;
    src_data[s*32 +: 32]  = dat;
  endtask

  task automatic clear_srcs();
    src_valid = '0;
    src_index = '0;
    src_data  = '0;
  endtask

  task automatic return_credits(input logic [3:0] mask, input int n);
    dst_credit_return = mask;
    repeat (n) tick();
    dst_credit_return = '0;
  endtask

  // Reset state and proof that dst 0 starts with four credits.
  task automatic test_reset();
    reset = 1'b1;
    clear_srcs();
    dst_credit_return = '0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    checks++; if (src_ready !== 4'b0000) begin failures++; $display("FAIL reset_ready got=%b exp=0000", src_ready); end
    checks++; if (dst_valid !== 4'b0000) begin failures++; $display("FAIL reset_dst_valid got=%b exp=0000", dst_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (dst_index !== 32'h0 || dst_data !== 128'h0) begin failures++; $display("FAIL reset_dst_payload idx=%h data=%h exp=0", dst_index, dst_data); end
    // src3 so that rr_ptr[0] wraps back to 0 afterwards.
    set_src(3, 1'b1, 8'h00, 32'h3333_0000);
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (src_ready !== 4'b1000) begin failures++; $display("FAIL reset_credit_grant%0d got=%b exp=1000", k, src_ready); end
      tick();
    end
    #1;
    checks++; if (src_ready !== 4'b0000) begin failures++; $display("FAIL reset_credit_exhausted got=%b exp=0000", src_ready); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL reset_credit_busy got=%b exp=1", busy); end
    clear_srcs();
    return_credits(4'b0001, 4);
  endtask

  // One packet from src0 to bank 1 with one-cycle latency.
  task automatic test_single();
    set_src(0, 1'b1, 8'h05, 32'hA5A5_A5A5);
    #1;
    checks++; if (src_ready !== 4'b0001) begin failures++; $display("FAIL single_ready got=%b exp=0001", src_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy got=%b exp=0", busy); end
    tick();
    clear_srcs();
    #1;
    checks++; if (dst_valid !== 4'b0010) begin failures++; $display("FAIL single_dst_valid got=%b exp=0010", dst_valid); end
    checks++; if (dst_index[15:8] !== 8'h05) begin failures++; $display("FAIL single_dst_index got=%h exp=05", dst_index[15:8]); end
    checks++; if (dst_data[63:32] !== 32'hA5A5_A5A5) begin failures++; $display("FAIL single_dst_data got=%h exp=a5a5a5a5", dst_data[63:32]); end
    return_credits(4'b0010, 1);
    #1;
    checks++; if (dst_valid !== 4'b0000) begin failures++; $display("FAIL single_strobe_clear got=%b exp=0000", dst_valid); end
  endtask

  // All four sources on bank 0, credit returned every cycle.
  task automatic test_round_robin();
    int exp_order [5] = '{0, 1, 2, 3, 0};
    for (int s = 0; s < 4; s++) set_src(s, 1'b1, 8'h00, 32'hD000_0000 + s);
    dst_credit_return = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if (src_ready !== (4'b0001 << exp_order[k])) begin failures++; $display("FAIL rr_grant%0d got=%b exp_src=%0d", k, src_ready, exp_order[k]); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rr_busy%0d got=%b exp=1", k, busy); end
      if (k > 0) begin
        checks++; if (dst_valid !== 4'b0001 || dst_data[31:0] !== 32'hD000_0000 + exp_order[k-1]) begin
          failures++; $display("FAIL rr_dst%0d valid=%b data=%h exp_data=%h", k, dst_valid, dst_data[31:0], 32'hD000_0000 + exp_order[k-1]);
        end
      end
      tick();
    end
    clear_srcs();
    dst_credit_return = '0;
    #1;
    checks++; if (dst_valid !== 4'b0001 || dst_data[31:0] !== 32'hD000_0000) begin failures++; $display("FAIL rr_last_dst valid=%b data=%h exp=d0000000", dst_valid, dst_data[31:0]); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rr_idle_busy got=%b exp=0", busy); end
  endtask

  // Credit exhaustion on bank 2, single-pulse refill, saturation of returns.
  task automatic test_credit_stall();
    set_src(0, 1'b1, 8'h02, 32'hC0DE_0002);
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (src_ready !== 4'b0001 || busy !== 1'b0) begin failures++; $display("FAIL stall_grant%0d ready=%b busy=%b exp=0001/0", k, src_ready, busy); end
      tick();
    end
    for (int k = 4; k < 7; k++) begin
      #1;
      checks++; if (src_ready !== 4'b0000 || busy !== 1'b1) begin failures++; $display("FAIL stall_blocked%0d ready=%b busy=%b exp=0000/1", k, src_ready, busy); end
      tick();
    end
    // Return arrives while credit is zero: no grant this cycle.
    dst_credit_return = 4'b0100;
    #1;
    checks++; if (src_ready !== 4'b0000) begin failures++; $display("FAIL stall_return_same_cycle got=%b exp=0000", src_ready); end
    tick();
    dst_credit_return = '0;
    #1;
    checks++; if (src_ready !== 4'b0001) begin failures++; $display("FAIL stall_refill_grant got=%b exp=0001", src_ready); end
    checks++; if (dst_valid !== 4'b0000) begin failures++; $display("FAIL stall_no_strobe got=%b exp=0000", dst_valid); end
`ifdef XBAR_ARB_STATS_EN
    checks++; if (stall_count[47:32] !== 16'd4) begin failures++; $display("FAIL stall_count got=%0d exp=4", stall_count[47:32]); end
`endif
    tick();
    #1;
    checks++; if (src_ready !== 4'b0000) begin failures++; $display("FAIL stall_only_one got=%b exp=0000", src_ready); end
    checks++; if (dst_valid !== 4'b0100 || dst_index[23:16] !== 8'h02) begin failures++; $display("FAIL stall_refill_dst valid=%b idx=%h exp=0100/02", dst_valid, dst_index[23:16]); end
    clear_srcs();
    // Five returns into an empty counter: the fifth must be ignored.
    return_credits(4'b0100, 5);
    set_src(1, 1'b1, 8'h06, 32'h0000_0006);
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (src_ready !== 4'b0010) begin failures++; $display("FAIL sat_grant%0d got=%b exp=0010", k, src_ready); end
      tick();
    end
    #1;
    checks++; if (src_ready !== 4'b0000) begin failures++; $display("FAIL sat_limit got=%b exp=0000", src_ready); end
    clear_srcs();
    return_credits(4'b0100, 4);
  endtask

  // Four sources to four different banks in the same cycle.
  task automatic test_simultaneous();
    for (int s = 0; s < 4; s++) set_src(s, 1'b1, 8'(s), 32'h5100_0000 + s);
    #1;
    checks++; if (src_ready !== 4'b1111) begin failures++; $display("FAIL simul_ready got=%b exp=1111", src_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL simul_busy got=%b exp=0", busy); end
    tick();
    clear_srcs();
    #1;
    checks++; if (dst_valid !== 4'b1111) begin failures++; $display("FAIL simul_dst_valid got=%b exp=1111", dst_valid); end
    for (int d = 0; d < 4; d++) begin
      checks++; if (dst_index[d*8 +: 8] !== 8'(d) || dst_data[d*32 +: 32] !== 32'h5100_0000 + d) begin
        failures++; $display("FAIL simul_dst%0d idx=%h data=%h exp_idx=%0d", d, dst_index[d*8 +: 8], dst_data[d*32 +: 32], d);
      end
    end
    return_credits(4'b1111, 1);
  endtask

  // Reset while bank 1 is out of credit and strobing.
  task automatic test_reset_mid();
    set_src(1, 1'b1, 8'h01, 32'h0000_0011);
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (src_ready !== 4'b0010) begin failures++; $display("FAIL rmid_fill%0d got=%b exp=0010", k, src_ready); end
      tick();
    end
    #1;
    checks++; if (dst_valid !== 4'b0010 || src_ready !== 4'b0000) begin failures++; $display("FAIL rmid_pre valid=%b ready=%b exp=0010/0000", dst_valid, src_ready); end
    reset = 1'b1;
    dst_credit_return = 4'b0010;
    tick();
    reset = 1'b0;
    dst_credit_return = '0;
    #1;
    checks++; if (dst_valid !== 4'b0000) begin failures++; $display("FAIL rmid_dst_valid got=%b exp=0000", dst_valid); end
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (src_ready !== 4'b0010) begin failures++; $display("FAIL rmid_grant%0d got=%b exp=0010", k, src_ready); end
      tick();
    end
    #1;
    checks++; if (src_ready !== 4'b0000) begin failures++; $display("FAIL rmid_limit got=%b exp=0000", src_ready); end
    clear_srcs();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_credit_stall();
    test_simultaneous();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
